toggle_event_rx: RTL and testbench
==================================

# toggle_event_rx

- Receive end of a toggle-signalled event link: the remote side is a T flip-flop (t=1 for one cycle flips its q), whose q drives `t_in`.
- This block synchronizes `t_in`, detects each level change and converts it back into one discrete event.
- Events are buffered as a pending count and presented on a valid/ready handshake.
- Sits at the consumer side of any T-FF-based event or pulse-transfer path.

## Interface

Parameters:
- SYNC_STAGES, default 2: synchronizer flops on `t_in`; legal ≥2.
- PEND_MAX, default 3: maximum buffered events; legal 1..255.
- CNT_W, default 8: width of the event counter (used only with the counter feature).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- t_in  input  1  toggle-encoded level from the remote T flip-flop; asynchronous to clk permitted.
- clr  input  1  synchronous clear of pending count, overflow flag and counter.
- evt_ready  input  1  consumer accepts one event this cycle.
- evt_valid  output  1  one or more events pending.
- pend  output  $clog2(PEND_MAX+1)  current pending count.
- ovf  output  1  sticky: an event was dropped.
- q_sync  output  1  synchronized copy of `t_in` (last sync stage).
- evt_cnt  output  CNT_W  total detected events; present only with `TOGGLE_RX_CNT_EN`.

## Operation

- Reset (rst=0, async): all sync stages, the previous-level flop, `pend`, `ovf` and `evt_cnt` go to 0. Outputs during and after reset: evt_valid=0, pend=0, ovf=0, q_sync=0, evt_cnt=0.
- Detect: `det = q_sync ^ prev`; `prev <= q_sync` every cycle. Each `det` is exactly one event, for both rising and falling toggles.
- Pop: `pop = evt_valid & evt_ready`; `evt_valid = (pend != 0)`. `evt_ready` while `pend` = 0 is ignored.
- Pending count update, priority order:
  1. clr=1: pend←0, ovf←0, evt_cnt←0. A `det` or `pop` in the same cycle is discarded. The sync chain and `prev` are not cleared, so no spurious event follows.
  2. det & pop: pend unchanged.
  3. det only, pend<PEND_MAX: pend+1.
  4. det only, pend==PEND_MAX: event dropped, pend unchanged, ovf←1. ovf stays 1 until clr or reset.
  5. pop only: pend−1.
- Counter (macro on): evt_cnt+1 on every `det`, including dropped events. It wraps modulo 2^CNT_W, so 2^CNT_W−1 → 0 with no flag.
- Reset release with `t_in`=1: q_sync reaches 1 and one event is reported. This is the required behaviour, because a remote T-FF reset is expected to hold 0.
- Reset asserted mid-operation: pending events are lost. There is no partial-state retention.

## Timing

- E0 is the first clk edge at which sync stage 0 captures a new `t_in` level.
- q_sync changes after edge E0+SYNC_STAGES−1.
- `det` is high in the cycle after that change.
- pend and evt_valid update at edge E0+SYNC_STAGES. Detection latency is therefore SYNC_STAGES edges (2 with defaults).
- A pop takes effect at the edge where evt_valid & evt_ready are both high; pend and evt_valid reflect it in the next cycle. Back-to-back pops are one per cycle.
- Maximum toggle rate: `t_in` must hold each level ≥ SYNC_STAGES+1 clk cycles. Faster toggles may be merged or lost and are not flagged.
- All outputs are registered except evt_valid, which is combinational from `pend` only. There is no input-to-output combinational path.

## Configuration

- `TOGGLE_RX_CNT_EN` defined: the CNT_W-bit `evt_cnt` register and output port exist and behave as described under Operation.
- `TOGGLE_RX_CNT_EN` undefined: the `evt_cnt` port and its register are removed. All other behaviour and timing are identical.

## Test plan

- Reset/idle: rst=0 with t_in=0, then release and hold 20 cycles → evt_valid=0, pend=0, ovf=0, q_sync=0, evt_cnt=0 throughout.
- Single toggle, latency: t_in 0→1 captured at E0, evt_ready=0 → pend=1 and evt_valid=1 exactly after E0+2. Then a one-cycle evt_ready → pend=0 next cycle. Then t_in 1→0 → a second event is detected.
- Overflow: 5 toggles spaced 4 cycles apart with evt_ready=0 (PEND_MAX=3) → pend saturates at 3, ovf=1 after the 4th event, evt_cnt=5. Then 3 pops → pend=0 while ovf stays 1.
- Simultaneous det and pop: pend=2, and a det coincides with a pop → pend remains 2. With pend=0, a det coincides with evt_ready=1 → pend=1, since no pop occurs while evt_valid=0.
- clr priority: pend=3, ovf=1, and clr=1 in the same cycle as a det → pend=0, ovf=0, evt_cnt=0. No event is reported in the following 10 cycles.
- Wrap and reset mid-operation: with CNT_W=8, 256 spaced toggles → evt_cnt returns to 0. Assert rst with pend=2 → all outputs 0 asynchronously. Release with t_in=1 → exactly one event (pend=1) after 2 edges.

Source files
------------

// File: rtl/toggle_event_rx.sv
// ---------------------------------------------------------------------------
// toggle_event_rx
//
// This is the receive end of a toggle-signalled event link. The remote side
// is a T flip-flop, and its q output drives t_in. This block synchronizes
// t_in into the clk domain and turns every level change into one discrete
// event. Events are buffered as a saturating pending count, and they are
// presented to the consumer on a valid/ready handshake.
//
// Optional feature macro: TOGGLE_RX_CNT_EN
//   When this macro is defined, a CNT_W-bit free-running event counter
//   (evt_cnt) exists. It counts every detected event, including dropped ones.
//
// Parameters
//   SYNC_STAGES : number of synchronizer flops on t_in (2 or more)
//   PEND_MAX    : maximum number of buffered events (1..255)
//   CNT_W       : width of evt_cnt (only used when TOGGLE_RX_CNT_EN is set)
//
// Ports
//   clk       : clock; all logic runs on the rising edge
//   rst       : asynchronous, active-low reset
//   t_in      : toggle-encoded level from the remote T flip-flop (async)
//   clr       : synchronous clear of pend, ovf and evt_cnt
//   evt_ready : consumer accepts one event this cycle
//   evt_valid : one or more events pending (combinational from pend only)
//   pend      : current pending event count
//   ovf       : sticky flag, set when an event was dropped
//   q_sync    : synchronized copy of t_in (last synchronizer stage)
//   evt_cnt   : total detected events, wraps (TOGGLE_RX_CNT_EN only)
// ---------------------------------------------------------------------------
module toggle_event_rx #(
    parameter  int SYNC_STAGES = 2,
    parameter  int PEND_MAX    = 3,
    parameter  int CNT_W       = 8,
    localparam int PEND_W      = $clog2(PEND_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t_in,
    input  logic              clr,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pend,
    output logic              ovf,
    output logic              q_sync
`ifdef TOGGLE_RX_CNT_EN
    ,
    output logic [CNT_W-1:0]  evt_cnt
`endif
);

    localparam logic [PEND_W-1:0] PendFull = PEND_W'(PEND_MAX);

    // Reject illegal configurations at elaboration time.
    if (SYNC_STAGES < 2 || PEND_MAX < 1 || PEND_MAX > 255 || CNT_W < 1) begin : g_param_check
        $error("toggle_event_rx: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PEND_W-1:0]      pend_q, pend_d;
    logic                   ovf_q, ovf_d;
    logic                   det;
    logic                   pop;

    // Synchronizer chain and previous-level flop. clr does not touch these,
    // so clearing the pending state cannot create a false edge afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Either a rising or a falling level change counts as exactly one event.
    assign det       = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign evt_valid = (pend_q != '0);
    assign pop       = evt_valid & evt_ready;

    // Next pending count and overflow flag. clr wins over everything else.
    // A detect that coincides with a pop cancels out. A detect that arrives
    // when the buffer is already full is dropped and recorded in ovf.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (clr) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (det && !pop) begin
            if (pend_q == PendFull) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (pop && !det) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend   = pend_q;
    assign ovf    = ovf_q;
    assign q_sync = sync_q[SYNC_STAGES-1];

`ifdef TOGGLE_RX_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Total event counter. Dropped events still count, and it wraps silently.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (det) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign evt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_toggle_event_rx.sv
// ---------------------------------------------------------------------------
// tb_toggle_event_rx
//
// Self-checking bench for toggle_event_rx with default parameters.
// The reference model works from the timing rules. The t_in level sampled
// at every clock edge is recorded. The synchronized level and the event
// instants are derived from that history, and the pending, overflow and
// counter rules are then applied arithmetically.
// ---------------------------------------------------------------------------
module tb_toggle_event_rx;

    localparam int SYNC     = 2;
    localparam int PEND_MAX = 3;
    localparam int CNT_W    = 8;
    localparam int PW       = $clog2(PEND_MAX + 1);
    localparam int HIST     = 8192;

    logic          clk;
    logic          rst;
    logic          t_in;
    logic          clr;
    logic          evt_ready;
    logic          evt_valid;
    logic [PW-1:0] pend;
    logic          ovf;
    logic          q_sync;
`ifdef TOGGLE_RX_CNT_EN
    logic [CNT_W-1:0] evt_cnt;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    // Model state
    bit samp [0:HIST-1];
    int edgeNo  = 0;
    int lastRst = 0;
    int mPend   = 0;
    bit mOvf    = 0;
    int mCnt    = 0;

    toggle_event_rx #(
        .SYNC_STAGES (SYNC),
        .PEND_MAX    (PEND_MAX),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .t_in      (t_in),
        .clr       (clr),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .pend      (pend),
        .ovf       (ovf),
        .q_sync    (q_sync)
`ifdef TOGGLE_RX_CNT_EN
        ,
        .evt_cnt   (evt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // t_in level as seen by synchronizer stage 0 at a given edge.
    // Edges that happened during reset count as 0.
    function automatic bit sampAt(int idx);
        if (idx <= lastRst || idx < 0) return 1'b0;
        return samp[idx % HIST];
    endfunction

    function automatic bit qExp();
        return sampAt(edgeNo - SYNC + 1);
    endfunction

    function automatic logic [PW+2:0] expVec();
        return {mPend != 0, mOvf, qExp(), PW'(mPend)};
    endfunction

    function automatic logic [PW+2:0] obsVec();
        return {evt_valid, ovf, q_sync, pend};
    endfunction

    // Apply the model rules for the coming edge, advance one edge, and
    // settle 1 ns past it.
    task automatic tick();
        int nxt;
        bit det;
        bit pop;
        nxt = edgeNo + 1;
        samp[nxt % HIST] = t_in;
        if (!rst) begin
            lastRst = nxt;
            mPend   = 0;
            mOvf    = 0;
            mCnt    = 0;
        end else begin
            det = sampAt(nxt - SYNC) != sampAt(nxt - SYNC - 1);
            pop = (mPend != 0) && evt_ready;
            if (clr) begin
                mPend = 0;
                mOvf  = 0;
                mCnt  = 0;
            end else begin
                if (det) mCnt = (mCnt + 1) % (1 << CNT_W);
                if (det && !pop) begin
                    if (mPend < PEND_MAX) mPend++;
                    else mOvf = 1;
                end else if (pop && !det) begin
                    mPend--;
                end
            end
        end
        @(posedge clk);
        edgeNo = nxt;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; t_in = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        repeat (3) tick();
        testsRun++;
        if (obsVec() !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: got %b want 0", obsVec());
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            testsRun++;
            if (obsVec() !== '0 || expVec() !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_idle cyc%0d: got %b model %b want 0", i, obsVec(), expVec());
            end
`ifdef TOGGLE_RX_CNT_EN
            testsRun++;
            if (evt_cnt !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_idle_cnt: got %0d want 0", evt_cnt);
            end
`endif
        end
    endtask

    task automatic test_single_toggle();
        evt_ready = 1'b0;
        t_in = 1'b1;
        tick();                                   // E0
        testsRun++;
        if (pend !== 0 || evt_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lat_e0: pend %0d valid %b want 0/0", pend, evt_valid);
        end
        tick();                                   // E0+1
        testsRun++;
        if (q_sync !== 1'b1 || pend !== 0) begin
            testsFailed++;
            $display("[TB] FAIL lat_e1: q_sync %b pend %0d want 1/0", q_sync, pend);
        end
        tick();                                   // E0+2
        testsRun++;
        if (pend !== 1 || evt_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL lat_e2: pend %0d valid %b want 1/1", pend, evt_valid);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        testsRun++;
        if (pend !== 0 || evt_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_pop: pend %0d valid %b want 0/0", pend, evt_valid);
        end
        tick();
        t_in = 1'b0;
        repeat (3) tick();
        testsRun++;
        if (pend !== 1 || obsVec() !== expVec()) begin
            testsFailed++;
            $display("[TB] FAIL falling_evt: got %b want %b", obsVec(), expVec());
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            t_in = ~t_in;
            for (int c = 0; c < 4; c++) begin
                tick();
                testsRun++;
                if (obsVec() !== expVec()) begin
                    testsFailed++;
                    $display("[TB] FAIL ovf_seq t%0d c%0d: got %b want %b", i, c, obsVec(), expVec());
                end
            end
            if (i == 3) begin
                testsRun++;
                if (ovf !== 1'b1 || pend !== 3) begin
                    testsFailed++;
                    $display("[TB] FAIL ovf_4th: ovf %b pend %0d want 1/3", ovf, pend);
                end
            end
        end
        testsRun++;
        if (pend !== 3 || ovf !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ovf_sat: pend %0d ovf %b want 3/1", pend, ovf);
        end
`ifdef TOGGLE_RX_CNT_EN
        testsRun++;
        if (evt_cnt !== 8'd5) begin
            testsFailed++;
            $display("[TB] FAIL ovf_cnt: got %0d want 5", evt_cnt);
        end
`endif
        evt_ready = 1'b1;
        repeat (3) tick();
        evt_ready = 1'b0;
        testsRun++;
        if (pend !== 0 || ovf !== 1'b1 || evt_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ovf_drain: pend %0d ovf %b valid %b want 0/1/0", pend, ovf, evt_valid);
        end
    endtask

    task automatic test_simultaneous();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        evt_ready = 1'b0;
        repeat (2) begin
            t_in = ~t_in;
            repeat (4) tick();
        end
        testsRun++;
        if (pend !== 2) begin
            testsFailed++;
            $display("[TB] FAIL sim_setup: pend %0d want 2", pend);
        end
        t_in = ~t_in;
        repeat (2) tick();
        evt_ready = 1'b1;
        tick();                                   // det and pop together
        evt_ready = 1'b0;
        testsRun++;
        if (pend !== 2 || obsVec() !== expVec()) begin
            testsFailed++;
            $display("[TB] FAIL det_pop: pend %0d want 2 (got %b model %b)", pend, obsVec(), expVec());
        end
        evt_ready = 1'b1;
        repeat (2) tick();
        testsRun++;
        if (pend !== 0) begin
            testsFailed++;
            $display("[TB] FAIL sim_drain: pend %0d want 0", pend);
        end
        t_in = ~t_in;
        repeat (3) tick();                        // ready held high while empty
        evt_ready = 1'b0;
        testsRun++;
        if (pend !== 1 || evt_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL det_ready_empty: pend %0d valid %b want 1/1", pend, evt_valid);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic test_clr_priority();
        evt_ready = 1'b0;
        repeat (4) begin
            t_in = ~t_in;
            repeat (4) tick();
        end
        testsRun++;
        if (pend !== 3 || ovf !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL clr_setup: pend %0d ovf %b want 3/1", pend, ovf);
        end
        t_in = ~t_in;
        repeat (2) tick();
        clr = 1'b1;
        tick();                                   // clr together with det
        clr = 1'b0;
        testsRun++;
        if (pend !== 0 || ovf !== 1'b0 || obsVec() !== expVec()) begin
            testsFailed++;
            $display("[TB] FAIL clr_det: pend %0d ovf %b want 0/0", pend, ovf);
        end
`ifdef TOGGLE_RX_CNT_EN
        testsRun++;
        if (evt_cnt !== '0) begin
            testsFailed++;
            $display("[TB] FAIL clr_cnt: got %0d want 0", evt_cnt);
        end
`endif
        for (int i = 0; i < 10; i++) begin
            tick();
            testsRun++;
            if (pend !== 0 || evt_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL clr_quiet cyc%0d: pend %0d valid %b want 0/0", i, pend, evt_valid);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        int minHold;
        hold = 0;
        minHold = SYNC + 1 + $urandom_range(0, 3);
        for (int i = 0; i < 1200; i++) begin
            evt_ready = 1'($urandom_range(0, 2) == 0);
            clr       = 1'($urandom_range(0, 59) == 0);
            if (hold >= minHold && $urandom_range(0, 1) == 1) begin
                t_in = ~t_in;
                hold = 0;
                minHold = SYNC + 1 + $urandom_range(0, 3);
            end
            tick();
            hold++;
            testsRun++;
            if (obsVec() !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL random cyc%0d: got %b want %b", i, obsVec(), expVec());
            end
`ifdef TOGGLE_RX_CNT_EN
            testsRun++;
            if (evt_cnt !== CNT_W'(mCnt)) begin
                testsFailed++;
                $display("[TB] FAIL random_cnt cyc%0d: got %0d want %0d", i, evt_cnt, mCnt);
            end
`endif
        end
        clr = 1'b0;
        evt_ready = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_wrap();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            t_in = ~t_in;
            repeat (4) tick();
            testsRun++;
            if (obsVec() !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL wrap_seq t%0d: got %b want %b", i, obsVec(), expVec());
            end
        end
        evt_ready = 1'b0;
`ifdef TOGGLE_RX_CNT_EN
        testsRun++;
        if (evt_cnt !== '0) begin
            testsFailed++;
            $display("[TB] FAIL wrap_cnt: got %0d want 0", evt_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        repeat (2) begin
            t_in = ~t_in;
            repeat (4) tick();
        end
        testsRun++;
        if (pend !== 2) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_setup: pend %0d want 2", pend);
        end
        #3;
        rst = 1'b0;                               // asynchronous, between edges
        lastRst = edgeNo;
        mPend = 0; mOvf = 0; mCnt = 0;
        #1;
        testsRun++;
        if (obsVec() !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rst_async: got %b want 0", obsVec());
        end
`ifdef TOGGLE_RX_CNT_EN
        testsRun++;
        if (evt_cnt !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rst_async_cnt: got %0d want 0", evt_cnt);
        end
`endif
        t_in = 1'b1;
        repeat (3) tick();
        testsRun++;
        if (obsVec() !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rst_held: got %b want 0", obsVec());
        end
        rst = 1'b1;
        tick();                                   // E0 captures t_in=1
        tick();
        testsRun++;
        if (q_sync !== 1'b1 || pend !== 0) begin
            testsFailed++;
            $display("[TB] FAIL rel_e1: q_sync %b pend %0d want 1/0", q_sync, pend);
        end
        tick();
        testsRun++;
        if (pend !== 1 || evt_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rel_event: pend %0d valid %b want 1/1", pend, evt_valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            testsRun++;
            if (pend !== 1 || obsVec() !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL rel_once cyc%0d: pend %0d want 1", i, pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_toggle();
        test_overflow();
        test_simultaneous();
        test_clr_priority();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
